// File: rtl/apb_arb_master.sv
// rtl/apb_arb_master.sv - two-requester round-robin APB master with registered outputs.
// Optional macro APB_ARB_TIMEOUT_EN adds a 16-cycle ACCESS wait-state timeout.
module apb_arb_master #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req0_done,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_err,
    output logic                  req1_done,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic                  gnt
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state, state_nxt;
    logic                  psel_nxt, penable_nxt, pwrite_nxt, gnt_nxt;
    logic [ADDR_WIDTH-1:0] paddr_nxt;
    logic [DATA_WIDTH-1:0] pwdata_nxt;
    logic                  req0_done_nxt, req1_done_nxt, req0_err_nxt, req1_err_nxt;
    logic [DATA_WIDTH-1:0] req0_rdata_nxt, req1_rdata_nxt;
    logic                  elig0, elig1, pick1;
    logic                  fin, fin_err;
    logic [DATA_WIDTH-1:0] fin_rdata;
`ifdef APB_ARB_TIMEOUT_EN
    logic [3:0]            wait_cnt, wait_cnt_nxt;
`endif

    // A requester still showing done is about to drop valid, so it must not win again.
    assign elig0 = req0_valid && !req0_done;
    assign elig1 = req1_valid && !req1_done;
    assign pick1 = elig1 && (!elig0 || !gnt);

    always_comb begin
        state_nxt      = state;
        psel_nxt       = psel;
        penable_nxt    = penable;
        pwrite_nxt     = pwrite;
        paddr_nxt      = paddr;
        pwdata_nxt     = pwdata;
        gnt_nxt        = gnt;
        req0_done_nxt  = 1'b0;
        req1_done_nxt  = 1'b0;
        req0_err_nxt   = req0_err;
        req1_err_nxt   = req1_err;
        req0_rdata_nxt = req0_rdata;
        req1_rdata_nxt = req1_rdata;
        fin            = 1'b0;
        fin_err        = 1'b0;
        fin_rdata      = '0;
`ifdef APB_ARB_TIMEOUT_EN
        wait_cnt_nxt   = wait_cnt;
`endif
        case (state)
            IDLE: begin
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
                if (elig0 || elig1) begin
                    state_nxt  = SETUP;
                    psel_nxt   = 1'b1;
                    gnt_nxt    = pick1;
                    pwrite_nxt = pick1 ? req1_write : req0_write;
                    paddr_nxt  = pick1 ? req1_addr  : req0_addr;
                    pwdata_nxt = pick1 ? req1_wdata : req0_wdata;
                end
            end
            SETUP: begin
                state_nxt   = ACCESS;
                psel_nxt    = 1'b1;
                penable_nxt = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                wait_cnt_nxt = '0;
`endif
            end
            ACCESS: begin
                if (pready) begin
                    fin       = 1'b1;
                    fin_err   = pslverr;
                    fin_rdata = pwrite ? '0 : prdata;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (wait_cnt == 4'hF) begin
                    fin       = 1'b1;
                    fin_err   = 1'b1;
                    fin_rdata = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase

        if (fin) begin
            state_nxt   = IDLE;
            psel_nxt    = 1'b0;
            penable_nxt = 1'b0;
            if (gnt) begin
                req1_done_nxt  = 1'b1;
                req1_err_nxt   = fin_err;
                req1_rdata_nxt = fin_rdata;
            end else begin
                req0_done_nxt  = 1'b1;
                req0_err_nxt   = fin_err;
                req0_rdata_nxt = fin_rdata;
            end
        end
    end

    // gnt resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state      <= IDLE;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            gnt        <= 1'b1;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_err   <= 1'b0;
            req1_err   <= 1'b0;
            req0_rdata <= '0;
            req1_rdata <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            state      <= state_nxt;
            psel       <= psel_nxt;
            penable    <= penable_nxt;
            pwrite     <= pwrite_nxt;
            paddr      <= paddr_nxt;
            pwdata     <= pwdata_nxt;
            gnt        <= gnt_nxt;
            req0_done  <= req0_done_nxt;
            req1_done  <= req1_done_nxt;
            req0_err   <= req0_err_nxt;
            req1_err   <= req1_err_nxt;
            req0_rdata <= req0_rdata_nxt;
            req1_rdata <= req1_rdata_nxt;
`ifdef APB_ARB_TIMEOUT_EN
            wait_cnt   <= wait_cnt_nxt;
`endif
        end
    end

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have port pclk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port preset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have, for n in {0,1}, ports reqn_valid (input, 1, command pending), reqn_write (input, 1, 1=write), reqn_addr (input, ADDR_WIDTH, address) and reqn_wdata (input, DATA_WIDTH, write data).
REQ-006 SHALL have, for n in {0,1}, ports reqn_done (output, 1, one-cycle completion pulse), reqn_rdata (output, DATA_WIDTH, read result) and reqn_err (output, 1, error status, valid with done).
REQ-007 SHALL have APB master ports psel, penable and pwrite (output, 1 each), paddr (output, ADDR_WIDTH) and pwdata (output, DATA_WIDTH).
REQ-008 SHALL have APB slave-response ports prdata (input, DATA_WIDTH), pready (input, 1) and pslverr (input, 1).
REQ-009 SHALL have port gnt, output, 1, index of the requester owning the current or last transfer.

Function
REQ-010 SHALL implement FSM states IDLE, SETUP and ACCESS; all outputs are registered.
REQ-011 IDLE: psel=0, penable=0; on an edge with an eligible requester valid, SHALL latch that requester's write/addr/wdata into pwrite/paddr/pwdata, set gnt and go to SETUP.
REQ-012 A requester is ineligible in a cycle where its reqn_done=1 (the requester drops valid in response to done).
REQ-013 Arbitration SHALL be round-robin: single eligible requester wins; both eligible -> the requester not equal to last gnt wins.
REQ-014 SETUP: psel=1, penable=0; SHALL unconditionally go to ACCESS on the next edge.
REQ-015 ACCESS: psel=1, penable=1; paddr/pwrite/pwdata SHALL stay stable while pready=0 (wait states, unbounded unless REQ-022).
REQ-016 ACCESS with pready=1 at an edge: SHALL go to IDLE and assert req[gnt]_done for exactly the following cycle.
REQ-017 On completion SHALL latch req[gnt]_err=pslverr and req[gnt]_rdata=prdata for reads or 0 for writes; these values hold until that requester's next completion.
REQ-018 Latency: valid sampled in IDLE at edge k -> SETUP cycle k+1, ACCESS cycle k+2, done cycle k+3 with zero wait states; each wait state adds 1.
REQ-019 Back-to-back: at least one IDLE cycle SHALL separate transfers; with both requesters continuously valid, grants alternate 0,1,0,1.
REQ-020 The block SHALL never assert both done outputs in the same cycle, nor assert penable without psel.

Reset
REQ-021 preset=1 SHALL immediately force state IDLE, psel/penable/pwrite=0, paddr/pwdata=0, both done/err=0, both rdata=0, and gnt=1 (so requester 0 wins the first tie); any in-flight transfer is abandoned without done.

Configuration
REQ-022 With macro APB_ARB_TIMEOUT_EN defined, a 4-bit wait counter SHALL count consecutive ACCESS cycles with pready=0; on the 16th such edge the block SHALL go to IDLE and pulse req[gnt]_done with err=1 and rdata=0.
REQ-023 With APB_ARB_TIMEOUT_EN undefined, no counter SHALL exist and ACCESS waits indefinitely for pready.

Verification
REQ-024 Reset then req0 write addr=0x010 wdata=0xDEADBEEF, pready=1 -> psel at cycle k+1, penable at k+2, req0_done at k+3, req0_err=0.
REQ-025 req1 read addr=0x010 after REQ-024 against the slave -> req1_rdata=0xDEADBEEF, req1_err=0, gnt=1.
REQ-026 req0 and req1 both valid from reset and held -> grant order 0,1,0,1; each transfer separated by one IDLE cycle.
REQ-027 pready held low 3 ACCESS cycles, pslverr=1 on completion -> paddr stable for 4 ACCESS cycles, done one cycle after pready, err=1.
REQ-028 preset pulsed high during ACCESS -> psel/penable=0 immediately, no done pulse, next tie grants req0.
REQ-029 With APB_ARB_TIMEOUT_EN defined and pready stuck at 0 -> done with err=1 and rdata=0 after 16 ACCESS cycles; without the macro -> no done after 100 cycles.
